// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: one outstanding fetch from a loadable word memory; macro IFR_WAIT_EN adds wait states.
// Latency: rsp_valid 1 cycle after acceptance, or WAIT_CYCLES+1 cycles with IFR_WAIT_EN defined.
// Backpressure: response held until rsp_ready; req_ready is low from acceptance until the response retires.
module instr_fetch_responder #(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic [31:0]           req_addr,
   output logic                  req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_instr,
   output logic                  rsp_err,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [31:0]           load_data,
   output logic [15:0]           fetch_count
);

   localparam logic [31:0] NOP_INSTR = 32'hE1A00000;
   localparam int          WORDS     = 1 << DEPTH_LOG2;

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
      $error("WAIT_CYCLES must be in 1..15");
   end

`ifdef IFR_WAIT_EN
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   logic [3:0]            wait_cnt;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic                  fault_q;
`else
   typedef enum logic [0:0] {IDLE, RESP} state_t;
`endif

   state_t                state;
   logic [31:0]           mem [WORDS];
   logic [DEPTH_LOG2-1:0] req_idx;
   logic                  req_fault;
   logic                  accept;

   assign req_idx   = req_addr[DEPTH_LOG2+1:2];
   assign req_fault = (req_addr[1:0] != 2'b00) || ((req_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
   assign accept    = req_valid && req_ready;

   // Memory is deliberately outside the reset domain so loaded code survives a core reset.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_instr   <= '0;
         fetch_count <= '0;
`ifdef IFR_WAIT_EN
         wait_cnt    <= '0;
         idx_q       <= '0;
         fault_q     <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
`ifdef IFR_WAIT_EN
                  state    <= WAIT;
                  wait_cnt <= WAIT_LOAD;
                  idx_q    <= req_idx;
                  fault_q  <= req_fault;
`else
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= req_fault;
                  if (req_fault) begin
                     rsp_instr <= NOP_INSTR;
                  end else begin
                     rsp_instr <= mem[req_idx];
                  end
`endif
               end
            end
`ifdef IFR_WAIT_EN
            WAIT: begin
               // Address was captured at acceptance; the live req_addr is ignored from here on.
               if (wait_cnt == 4'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= fault_q;
                  if (fault_q) begin
                     rsp_instr <= NOP_INSTR;
                  end else begin
                     rsp_instr <= mem[idx_q];
                  end
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
`endif
            RESP: begin
               if (rsp_ready) begin
                  state       <= IDLE;
                  rsp_valid   <= 1'b0;
                  req_ready   <= 1'b1;
                  fetch_count <= fetch_count + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench for instr_fetch_responder: random and directed fetches checked against a word-array model.
module tb_instr_fetch_responder;

`ifdef IFR_WAIT_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   localparam logic [31:0] NOP = 32'hE1A00000;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic        rsp_err;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [31:0] load_data;
   logic [15:0] fetch_count;

   logic [31:0] ref_mem [256];
   logic [32:0] exp_q [$];
   logic [15:0] model_count = 16'd0;
   int          n_checks = 0;
   int          n_fail = 0;

   instr_fetch_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_instr   (rsp_instr),
      .rsp_err     (rsp_err),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Fault = misaligned or beyond the 1 KiB (256-word) space; else the stored word.
   function automatic logic [32:0] model(input logic [31:0] a);
      if (a % 4 != 0 || a >= 32'd1024) return {1'b1, NOP};
      return {1'b0, ref_mem[a / 4]};
   endfunction

   always @(negedge clk) begin
      logic [32:0] e;
      if (!reset && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got instr %h with empty scoreboard", rsp_instr);
         end else begin
            e = exp_q.pop_front();
            check("rsp_instr", rsp_instr, e[31:0]);
            check("rsp_err", 32'(rsp_err), 32'(e[32]));
         end
         model_count = model_count + 16'd1;
      end
   end

   task automatic load_word(input logic [7:0] idx, input logic [31:0] d);
      load_en = 1'b1; load_addr = idx; load_data = d;
      @(posedge clk); #1;
      load_en = 1'b0;
      ref_mem[idx] = d;
   endtask

   // load_off >= 0 drives a load that many cycles after the acceptance cycle.
   task automatic fetch(input logic [31:0] addr, input int hold, input int load_off,
                        input logic [7:0] ld_idx, input logic [31:0] ld_dat);
      logic [32:0] e;
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("req_ready_idle", 32'(req_ready), 32'd1);
      e = model(addr);
      exp_q.push_back(e);
      req_valid = 1'b1; req_addr = addr; rsp_ready = (hold == 0);
      if (load_off == 0) begin
         load_en = 1'b1; load_addr = ld_idx; load_data = ld_dat;
      end
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; load_en = 1'b0;
      n = 1;
      while (!rsp_valid && n < 20) begin
         if (n == load_off) begin
            load_en = 1'b1; load_addr = ld_idx; load_data = ld_dat;
         end
         @(posedge clk); #1;
         load_en = 1'b0;
         n++;
      end
      if (load_off >= 0) ref_mem[ld_idx] = ld_dat;
      check("latency", 32'(n), 32'(LAT));
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_instr", rsp_instr, e[31:0]);
         check("hold_err", 32'(rsp_err), 32'(e[32]));
         check("hold_req_ready", 32'(req_ready), 32'd0);
         check("hold_count", 32'(fetch_count), 32'(model_count));
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("post_valid", 32'(rsp_valid), 32'd0);
      check("post_req_ready", 32'(req_ready), 32'd1);
      check("post_count", 32'(fetch_count), 32'(model_count));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_rsp_instr", rsp_instr, 32'd0);
      check("rst_fetch_count", 32'(fetch_count), 32'd0);
      // Loads are issued while reset is still asserted: they must land.
      for (int i = 0; i < 256; i++) load_word(8'(i), $urandom);
      reset = 1'b0;
      @(posedge clk); #1;

      load_word(8'd3, 32'hE3A01005);
      fetch(32'h0000_000C, 0, -1, 8'd0, 32'd0);
      check("first_count", 32'(fetch_count), 32'd1);
      fetch(32'h0000_0006, 0, -1, 8'd0, 32'd0);
      fetch(32'h0000_0400, 1, -1, 8'd0, 32'd0);
      fetch(32'h0000_000C, 5, -1, 8'd0, 32'd0);

      load_word(8'd5, 32'hAAAAAAAA);
      fetch(32'h0000_0014, 0, LAT - 1, 8'd5, 32'h11111111);
      fetch(32'h0000_0014, 0, -1, 8'd0, 32'd0);
      fetch(32'h0000_03FC, 2, -1, 8'd0, 32'd0);

      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 3) == 0) load_word(8'($urandom), $urandom);
         case ($urandom_range(0, 3))
            0, 1: a = {22'd0, 8'($urandom), 2'b00};
            2:    a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
            default: begin
               a = $urandom;
               a[10] = 1'b1;
               if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            end
         endcase
         fetch(a, $urandom_range(0, 3), -1, 8'd0, 32'd0);
      end

      // Reset while a fetch is in flight, with a load in the same cycle.
      req_valid = 1'b1; req_addr = 32'h0000_000C; rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b1; load_en = 1'b1; load_addr = 8'd7; load_data = 32'h7777_0007;
      @(posedge clk); #1;
      reset = 1'b0; load_en = 1'b0;
      ref_mem[7] = 32'h7777_0007;
      model_count = 16'd0;
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_count", 32'(fetch_count), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      fetch(32'h0000_001C, 0, -1, 8'd0, 32'd0);
      fetch(32'h0000_000C, 0, -1, 8'd0, 32'd0);
      fetch(32'h0000_0014, 0, -1, 8'd0, 32'd0);

      // Preload the counter near its limit, then fetch across the wrap.
      force dut.fetch_count = 16'hFFFD;
      @(posedge clk); #1;
      release dut.fetch_count;
      model_count = 16'hFFFD;
      check("preload_count", 32'(fetch_count), 32'h0000_FFFD);
      for (int k = 0; k < 3; k++) fetch({22'd0, 8'($urandom), 2'b00}, 0, -1, 8'd0, 32'd0);
      check("wrap_count", 32'(fetch_count), 32'd0);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
